// File: rtl/cloud_pkg.sv
// Shared constants, state type and spawn helpers for the cloud field.
package cloud_pkg;

  localparam int NUM_CLOUDS_MAX = 8;

  // Screen geometry in pixels
  localparam int WIDTH      = 46;
  localparam int GAME_WIDTH = 640;

  // Sky band: MAX_SKY_LEVEL is the top (smallest y), MIN_SKY_LEVEL the bottom
  localparam int MAX_SKY_LEVEL = 30;
  localparam int MIN_SKY_LEVEL = 71;

  // Horizontal spacing between successive clouds, in pixels
  localparam int MIN_CLOUD_GAP = 100;
  localparam int MAX_CLOUD_GAP = 400;

  // Game units per pixel
  localparam int SPEED_SCALE = 1024;

  // Datapath widths
  localparam int XG_W    = 21;
  localparam int XP_W    = 11;
  localparam int YP_W    = 10;
  localparam int GAP_W   = 11;
  localparam int SPEED_W = 15;

  // A cloud whose x_pos is at or below this has fully left the screen
  localparam logic signed [10:0] X_OFF = 11'(-WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    SWEEP,
    SPAWN,
    CRASHED
  } field_state_t;

  // Clamp the random level into the sky band
  function automatic logic [9:0] sky_level(input logic [9:0] r);
    if (r > 10'(MIN_SKY_LEVEL - MAX_SKY_LEVEL)) return 10'(MIN_SKY_LEVEL);
    return 10'(MAX_SKY_LEVEL) + r;
  endfunction

  // Clamp the random gap into the allowed spacing range
  function automatic logic [10:0] cloud_gap(input logic [10:0] r);
    if (r > 11'(MAX_CLOUD_GAP - MIN_CLOUD_GAP)) return 11'(MAX_CLOUD_GAP);
    return 11'(MIN_CLOUD_GAP) + r;
  endfunction

endpackage

// File: rtl/cloud_mover.sv
// Combinational parallax step for one cloud: scales the game speed, moves the
// fixed-point x, and flags the cloud once it has slid off the left edge.
module cloud_mover
  import cloud_pkg::*;
#(
  parameter int unsigned SPEED_COEFF = 205
) (
  input  logic signed [XG_W-1:0]    x_game,
  input  logic        [SPEED_W-1:0] speed,
  output logic signed [XG_W-1:0]    x_game_new,
  output logic signed [XP_W-1:0]    x_pos_new,
  output logic                      offscreen
);

  logic        [22:0]     product;
  logic signed [XG_W-1:0] delta;

  assign product    = 23'(32'(speed) * 32'(SPEED_COEFF));
  // Drop the 1/1024 fraction of the scaled speed; result is always positive
  assign delta      = {8'b0, product[22:10]};
  assign x_game_new = x_game - delta;
  // Top bits of x_game are x_game >>> 10, i.e. floor to whole pixels
  assign x_pos_new  = x_game_new[XG_W-1:10];
  assign offscreen  = (x_pos_new <= X_OFF);

endmodule

// File: rtl/cloud_field.sv
// Pool of background clouds. Each frame strobe sweeps the slots serially
// through a single mover, retires clouds that have left the screen and then
// considers one spawn. Optional macro CLOUD_DRIFT_EN keeps clouds drifting
// at DRIFT_SPEED after a crash instead of freezing them.
module cloud_field
  import cloud_pkg::*;
#(
  parameter int unsigned NUM_CLOUDS  = 4,
  parameter int unsigned SPEED_COEFF = 205,
  parameter int unsigned DRIFT_SPEED = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             update,
  input  logic [SPEED_W-1:0]               speed,
  input  logic                             start,
  input  logic                             crash,
  input  logic [9:0]                       level_rand,
  input  logic [10:0]                      gap_rand,
  output logic                             busy,
  output logic                             update_done,
  output logic [NUM_CLOUDS-1:0]            active,
  output logic [NUM_CLOUDS-1:0]            visible,
  output logic [NUM_CLOUDS*XP_W-1:0]       x_pos,
  output logic [NUM_CLOUDS*YP_W-1:0]       y_pos,
  output logic [$clog2(NUM_CLOUDS+1)-1:0]  count
);

  localparam int unsigned CW = $clog2(NUM_CLOUDS + 1);
  localparam int unsigned IW = (NUM_CLOUDS > 1) ? $clog2(NUM_CLOUDS) : 1;

  field_state_t state;
  logic [IW-1:0] idx;
  logic [IW-1:0] newest;
  logic          drift;

  logic signed [XG_W-1:0]  xg_q  [NUM_CLOUDS];
  logic signed [XP_W-1:0]  xp_q  [NUM_CLOUDS];
  logic        [YP_W-1:0]  yp_q  [NUM_CLOUDS];
  logic        [GAP_W-1:0] gap_q [NUM_CLOUDS];

  logic        [SPEED_W-1:0] mv_speed;
  logic signed [XG_W-1:0]    mv_xg;
  logic signed [XP_W-1:0]    mv_xp;
  logic                      mv_off;

  logic              free_found;
  logic [IW-1:0]     free_idx;
  logic signed [11:0] headroom;
  logic              gap_ok;
  logic              do_spawn;

  assign mv_speed = drift ? SPEED_W'(DRIFT_SPEED) : speed;

  cloud_mover #(
    .SPEED_COEFF (SPEED_COEFF)
  ) u_mover (
    .x_game     (xg_q[idx]),
    .speed      (mv_speed),
    .x_game_new (mv_xg),
    .x_pos_new  (mv_xp),
    .offscreen  (mv_off)
  );

  // Lowest-index free slot is the spawn target
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_CLOUDS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  // Distance the newest cloud has travelled must exceed its gap
  assign headroom = 12'(GAME_WIDTH) - {xp_q[newest][XP_W-1], xp_q[newest]};
  assign gap_ok   = headroom > $signed({1'b0, gap_q[newest]});
  assign do_spawn = free_found && ((count == '0) || gap_ok);

  // Flatten slot registers onto the output buses
  always_comb begin
    x_pos   = '0;
    y_pos   = '0;
    visible = '0;
    for (int i = 0; i < NUM_CLOUDS; i++) begin
      x_pos[i*XP_W +: XP_W] = xp_q[i];
      y_pos[i*YP_W +: YP_W] = yp_q[i];
      visible[i]            = active[i] && (xp_q[i] > X_OFF);
    end
  end

  // Field controller and slot storage; crash overrides every state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      newest      <= '0;
      drift       <= 1'b0;
      busy        <= 1'b0;
      update_done <= 1'b0;
      active      <= '0;
      count       <= '0;
      for (int i = 0; i < NUM_CLOUDS; i++) begin
        xg_q[i]  <= '0;
        xp_q[i]  <= '0;
        yp_q[i]  <= '0;
        gap_q[i] <= '0;
      end
    end else begin
      update_done <= 1'b0;
      if (crash) begin
        state <= CRASHED;
        busy  <= 1'b0;
        drift <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // First frame only places a cloud; nothing to move yet
            if (update && start) begin
              state <= SPAWN;
              busy  <= 1'b1;
            end
          end
          RUN: begin
            if (update) begin
              state <= SWEEP;
              idx   <= '0;
              busy  <= 1'b1;
            end
          end
          SWEEP: begin
            if (active[idx]) begin
              xg_q[idx] <= mv_xg;
              xp_q[idx] <= mv_xp;
              if (mv_off) begin
                active[idx] <= 1'b0;
                count       <= count - CW'(1);
              end
            end
            if (idx == IW'(NUM_CLOUDS - 1)) begin
              if (drift) begin
                // Post-crash drift never spawns
                state       <= CRASHED;
                busy        <= 1'b0;
                update_done <= 1'b1;
                drift       <= 1'b0;
              end else begin
                state <= SPAWN;
              end
            end else begin
              idx <= idx + IW'(1);
            end
          end
          SPAWN: begin
            if (do_spawn) begin
              active[free_idx] <= 1'b1;
              count            <= count + CW'(1);
              newest           <= free_idx;
              xg_q[free_idx]   <= XG_W'(GAME_WIDTH * SPEED_SCALE);
              xp_q[free_idx]   <= XP_W'(GAME_WIDTH);
              yp_q[free_idx]   <= sky_level(level_rand);
              gap_q[free_idx]  <= cloud_gap(gap_rand);
            end
            update_done <= 1'b1;
            busy        <= 1'b0;
            state       <= RUN;
          end
          CRASHED: begin
            if (start) begin
              state  <= IDLE;
              active <= '0;
              count  <= '0;
              newest <= '0;
              for (int i = 0; i < NUM_CLOUDS; i++) begin
                xg_q[i]  <= '0;
                xp_q[i]  <= '0;
                yp_q[i]  <= '0;
                gap_q[i] <= '0;
              end
            end else if (update) begin
`ifdef CLOUD_DRIFT_EN
              state <= SWEEP;
              idx   <= '0;
              busy  <= 1'b1;
              drift <= 1'b1;
`else
              update_done <= 1'b1;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/cloud_field.md
Name: cloud_field

Overview:
- Parametrised successor to the single-cloud background item. Manages a pool of NUM_CLOUDS cloud slots.
- Per frame it moves every active cloud with fixed-point parallax, retires clouds that have left the screen, and spawns new clouds by gap rule.
- Sits between the frame-update strobe and the background renderer. Collision logic never sees it.
- Slots are processed serially, one per cycle, so a single subtract/scale datapath serves the whole pool.

Parameters:
- NUM_CLOUDS, 4, number of cloud slots (1..8)
- SPEED_COEFF, 205, parallax multiplier; movement per frame = speed*SPEED_COEFF/1024 game units
- DRIFT_SPEED, 1024, speed value used while crashed (only with CLOUD_DRIFT_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- update  in  1  one-cycle frame strobe
- speed  in  15  game speed, scaled by 1024
- start  in  1  level; begins or restarts the field
- crash  in  1  pulse; freezes the field
- level_rand  in  10  random sky level, sampled at spawn
- gap_rand  in  11  random gap, sampled at spawn
- busy  out  1  sweep in progress
- update_done  out  1  one-cycle pulse when the frame's work is complete
- active  out  NUM_CLOUDS  slot occupied
- visible  out  NUM_CLOUDS  active && x_pos+WIDTH>0
- x_pos  out  NUM_CLOUDS*11  signed screen x per slot; slot i at bits [11i+10:11i]
- y_pos  out  NUM_CLOUDS*10  screen y per slot
- count  out  $clog2(NUM_CLOUDS+1)  number of active slots

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all slots inactive; x_game, x_pos, y_pos, gap zero; newest=0; busy, update_done, count all 0.
- States: IDLE, RUN, SWEEP, SPAWN, CRASHED.
- IDLE: update && start -> SPAWN. No movement on this frame.
- RUN: update -> SWEEP with idx=0. busy=1 from the next cycle.
- SWEEP: one slot per cycle, idx 0..NUM_CLOUDS-1, then -> SPAWN.
  - Inactive slot: skipped, but still consumes its cycle.
  - Active slot: x_game -= (speed*SPEED_COEFF)>>10. The product is 23-bit unsigned; x_game is 21-bit signed, in units of 1/1024 px.
  - x_pos = x_game>>>10 (arithmetic shift).
  - If the new x_pos+WIDTH <= 0, clear active in the same cycle.
- SPAWN (one cycle):
  - Spawn if a free slot exists and either count==0 or (GAME_WIDTH - x_pos[newest]) > gap[newest].
  - Target is the lowest-index free slot.
  - x_game=GAME_WIDTH*1024, x_pos=GAME_WIDTH.
  - y_pos = MAX_SKY_LEVEL + min(level_rand, MIN_SKY_LEVEL-MAX_SKY_LEVEL).
  - gap = MIN_CLOUD_GAP + min(gap_rand, MAX_CLOUD_GAP-MIN_CLOUD_GAP).
  - newest is set to the target slot.
  - Pool full: no spawn; retried next frame.
  - Then update_done=1 for one cycle, busy=0 -> RUN.
- Latency: update to update_done is NUM_CLOUDS+2 cycles from RUN, and 2 cycles from IDLE.
- update while busy: ignored, no queueing.
- crash: highest priority in any state. -> CRASHED next cycle. An in-flight sweep aborts with no update_done. Positions already written are kept.
- CRASHED:
  - update: no movement; update_done pulses the next cycle.
  - start: clear all slots, -> IDLE. The next update && start respawns.
- crash && start in the same cycle: crash wins.
- count always equals popcount(active) and is registered with it.
- Constants come from the shared package; WIDTH=46, GAME_WIDTH=640, sky levels 30..71, gaps 100..400.

Optional Feature:
- Macro CLOUD_DRIFT_EN.
- Defined: in CRASHED, update runs a full SWEEP using DRIFT_SPEED in place of speed. Retirement applies; no spawning. update_done arrives after NUM_CLOUDS+1 cycles.
- Undefined: CRASHED freezes all positions as described in Behaviour.

Decomposition:
- Extend cloud_pkg with:
  - field_state_t (IDLE, RUN, SWEEP, SPAWN, CRASHED)
  - NUM_CLOUDS_MAX=8
  - the existing geometry, sky and gap constants, and SPEED_SCALE
- One sub-module, cloud_mover: combinational next-x datapath. Inputs x_game and speed; outputs new x_game, x_pos and offscreen.

Test Plan:
- Reset, then update with start=1 in IDLE -> update_done 2 cycles later; slot0 active with x_pos=640. With level_rand=5, gap_rand=0: y_pos=35, gap=100, count=1.
- speed=10240, NUM_CLOUDS=4, one cloud at 640 -> after one frame x_game=655360-2050=653310, x_pos=637; update_done at NUM_CLOUDS+2=6 cycles.
- Cloud at x_pos=-46 after a move -> active cleared on that slot's sweep cycle; count decrements; visible=0.
- Gap rule: newest x_pos=541, gap=100 -> no spawn (99 is not >100). At x_pos=539 -> spawn into the lowest free slot. With all 4 slots full -> no spawn, count stays 4.
- crash pulsed at sweep idx 2 -> busy drops, no update_done. Later update -> positions unchanged (macro off), or moved by 205 game units (macro on, DRIFT_SPEED=1024).
- rst driven low mid-sweep (async) -> all outputs zero immediately. start in CRASHED -> all slots cleared, state IDLE.
